binary_mul_acc: RTL and testbench

Accumulator stage directly downstream of the 5×5 unsigned array multiplier. It consumes the registered 10-bit product stream and sums a programmable number of consecutive products into a wider result (dot product of two operand vectors). The result is presented on a valid/ready output port. The block shares the multiplier's clock, reset and global enable.

---
 rtl/binary_mul_acc_if.sv | 27 ++
 rtl/binary_mul_acc.sv | 98 +++++++++
 tb/tb_binary_mul_acc.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/binary_mul_acc_if.sv
// Handshake/data bundle between the product source, the accumulator and the result consumer.
// Accumulator side uses modport slave; the driver/consumer side uses modport master.
interface binary_mul_acc_if #(
  parameter int PW    = 10,
  parameter int CNT_W = 4,
  parameter int ACC_W = 14
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic [PW-1:0]    p_in;
  logic             p_valid;
  logic [ACC_W-1:0] sum;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;

  modport master (
    output start, len, p_in, p_valid, out_ready,
    input  busy, sum, out_valid, ovf
  );

  modport slave (
    input  start, len, p_in, p_valid, out_ready,
    output busy, sum, out_valid, ovf
  );
endinterface

// File: rtl/binary_mul_acc.sv
// Multiply-accumulate back end: sums len+1 products into a wide result behind a valid/ready port.
// Optional macro BINARY_MUL_ACC_SAT_EN: saturate sum on overflow instead of wrapping.
module binary_mul_acc #(
  parameter int PW    = 10,
  parameter int CNT_W = 4,
  parameter int ACC_W = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  binary_mul_acc_if.slave bus,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum_r, sum_add;
  logic [ACC_W:0]   add_full;
  logic [PW-1:0]    p_q;
  logic             carry;
  logic             ovf_r;
  logic             out_valid_r;
  logic             load;
  logic             acc_en;

  assign p_q      = bus.p_in;
  assign add_full = {1'b0, sum_r} + (ACC_W+1)'(p_q);
  assign carry    = add_full[ACC_W];

`ifdef BINARY_MUL_ACC_SAT_EN
  // Once the job has overflowed, sum is pinned at full scale until the next start.
  assign sum_add = (carry || ovf_r) ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
  assign sum_add = add_full[ACC_W-1:0];
`endif

  // Result port: a transfer happens on a rising edge where en, out_valid and
  // out_ready are all high; sum/ovf stay stable while out_valid waits for ready.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    acc_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.p_valid) begin
          acc_en = 1'b1;
          if (cnt == '0) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          load      = bus.start;
          state_nxt = bus.start ? S_ACCUM : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sum_r       <= '0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (en) begin
      state       <= state_nxt;
      out_valid_r <= (state_nxt == S_DONE);
      if (load) begin
        cnt   <= bus.len;
        sum_r <= '0;
        ovf_r <= 1'b0;
      end else if (acc_en) begin
        sum_r <= sum_add;
        if (carry) ovf_r <= 1'b1;
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.sum       = sum_r;
  assign bus.ovf       = ovf_r;
  assign bus.out_valid = out_valid_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_binary_mul_acc.sv
// Bench for binary_mul_acc: vector table, hand-written corner sequences and random jobs
// checked against an arithmetic model through an expected-result queue.
module tb_binary_mul_acc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  binary_mul_acc_if #(.PW(10), .CNT_W(4), .ACC_W(14)) bus ();
  binary_mul_acc_if #(.PW(10), .CNT_W(4), .ACC_W(10)) obus ();
  logic [1:0] st_dbg, ost_dbg;

  binary_mul_acc #(.PW(10), .CNT_W(4), .ACC_W(14)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus.slave), .state_dbg(st_dbg)
  );

  binary_mul_acc #(.PW(10), .CNT_W(4), .ACC_W(10)) u_ovf (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(obus.slave), .state_dbg(ost_dbg)
  );

  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];
  logic        exp_ovf_q[$];

  typedef struct {
    logic [3:0]        len;
    logic [15:0][9:0]  p;
    logic [13:0]       exp_sum;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run_job(input int l, input logic [15:0][9:0] p, input int gap_max,
                         input int rdy_dly, output logic [13:0] got_sum, output logic got_ovf);
    bus.start = 1'b1;
    bus.len   = 4'(l);
    tick();
    bus.start = 1'b0;
    chk("busy_rise", 32'(bus.busy), 1);
    for (int i = 0; i <= l; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      if (i == l) chk("valid_early", 32'(bus.out_valid), 0);
      bus.p_valid = 1'b1;
      bus.p_in    = p[i];
      tick();
      bus.p_valid = 1'b0;
    end
    chk("valid_rise", 32'(bus.out_valid), 1);
    for (int d = 0; d < rdy_dly; d++) begin
      tick();
      chk("valid_hold", 32'(bus.out_valid), 1);
      chk("busy_hold", 32'(bus.busy), 1);
    end
    got_sum = bus.sum;
    got_ovf = bus.ovf;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("valid_fall", 32'(bus.out_valid), 0);
    chk("busy_fall", 32'(bus.busy), 0);
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    logic [13:0] gs;
    logic        go;
    logic [15:0][9:0] rp;
    int          tsum;
    int          l;
    logic [31:0] ovf_exp_sum;

    bus.start = 0; bus.len = 0; bus.p_in = 0; bus.p_valid = 0; bus.out_ready = 0;
    obus.start = 0; obus.len = 0; obus.p_in = 0; obus.p_valid = 0; obus.out_ready = 0;

    // vector table: {len, products, expected sum, expected ovf}
    for (int i = 0; i < 5; i++) begin
      vecs[i].p = '0;
    end
    vecs[0].len = 4'd3;  for (int j = 0; j < 4; j++)  vecs[0].p[j] = 10'd961;
    vecs[0].exp_sum = 14'd3844; vecs[0].exp_ovf = 1'b0;
    vecs[1].len = 4'd15; for (int j = 0; j < 16; j++) vecs[1].p[j] = 10'd961;
    vecs[1].exp_sum = 14'd15376; vecs[1].exp_ovf = 1'b0;
    vecs[2].len = 4'd0;  vecs[2].p[0] = 10'd0;
    vecs[2].exp_sum = 14'd0; vecs[2].exp_ovf = 1'b0;
    vecs[3].len = 4'd7;  for (int j = 0; j < 8; j++)  vecs[3].p[j] = 10'(j * 100 + 1);
    vecs[3].exp_sum = 14'd2808; vecs[3].exp_ovf = 1'b0;
    vecs[4].len = 4'd1;  vecs[4].p[0] = 10'd1023; vecs[4].p[1] = 10'd1000;
    vecs[4].exp_sum = 14'd2023; vecs[4].exp_ovf = 1'b0;

    // reset state
    repeat (2) tick();
    chk("rst_sum", 32'(bus.sum), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_osum", 32'(obus.sum), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // table-driven jobs
    for (int i = 0; i < 5; i++) begin
      run_job(int'(vecs[i].len), vecs[i].p, 0, 2, gs, go);
      chk($sformatf("vec%0d_sum", i), 32'(gs), 32'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_ovf", i), 32'(go), 32'(vecs[i].exp_ovf));
    end

    // gaps plus en low mid-job
    bus.start = 1'b1; bus.len = 4'd2;
    tick();
    bus.start = 1'b0;
    bus.p_valid = 1'b1; bus.p_in = 10'd5;
    tick();
    bus.p_valid = 1'b0;
    chk("gap_sum1", 32'(bus.sum), 5);
    en = 1'b0;
    bus.p_valid = 1'b1; bus.p_in = 10'd50;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_hold_sum", 32'(bus.sum), 5);
      chk("en_hold_busy", 32'(bus.busy), 1);
    end
    en = 1'b1;
    bus.p_valid = 1'b0;
    repeat (2) tick();
    bus.p_valid = 1'b1; bus.p_in = 10'd12;
    tick();
    bus.p_valid = 1'b0;
    tick();
    chk("gap_not_done", 32'(bus.out_valid), 0);
    bus.p_valid = 1'b1; bus.p_in = 10'd100;
    tick();
    bus.p_valid = 1'b0;
    chk("gap_valid", 32'(bus.out_valid), 1);
    chk("gap_sum", 32'(bus.sum), 117);
    chk("gap_ovf", 32'(bus.ovf), 0);
    en = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("en_stall_hs", 32'(bus.out_valid), 1);
    en = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("en_hs_done", 32'(bus.out_valid), 0);

    // backpressure, ignored start, then back-to-back job
    bus.start = 1'b1; bus.len = 4'd0;
    tick();
    bus.start = 1'b0;
    bus.p_valid = 1'b1; bus.p_in = 10'd9;
    tick();
    bus.p_valid = 1'b0;
    chk("bp_valid", 32'(bus.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i % 2 == 0); bus.len = 4'd5;
      tick();
      chk("bp_sum", 32'(bus.sum), 9);
      chk("bp_valid_hold", 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1; bus.start = 1'b1; bus.len = 4'd0;
    tick();
    bus.out_ready = 1'b0; bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 1);
    chk("b2b_valid", 32'(bus.out_valid), 0);
    chk("b2b_clear", 32'(bus.sum), 0);
    bus.p_valid = 1'b1; bus.p_in = 10'd7;
    tick();
    bus.p_valid = 1'b0;
    chk("b2b_out", 32'(bus.out_valid), 1);
    chk("b2b_sum", 32'(bus.sum), 7);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("b2b_idle", 32'(bus.busy), 0);

    // overflow on the 10-bit accumulator
`ifdef BINARY_MUL_ACC_SAT_EN
    ovf_exp_sum = 1023;
`else
    ovf_exp_sum = (961 + 961) % 1024;
`endif
    obus.start = 1'b1; obus.len = 4'd1;
    tick();
    obus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      obus.p_valid = 1'b1; obus.p_in = 10'd961;
      tick();
    end
    obus.p_valid = 1'b0;
    chk("ovf_valid", 32'(obus.out_valid), 1);
    chk("ovf_sum", 32'(obus.sum), ovf_exp_sum);
    chk("ovf_flag", 32'(obus.ovf), 1);
    obus.out_ready = 1'b1; obus.start = 1'b1; obus.len = 4'd0;
    tick();
    obus.out_ready = 1'b0; obus.start = 1'b0;
    chk("ovf_clear", 32'(obus.ovf), 0);
    obus.p_valid = 1'b1; obus.p_in = 10'd1;
    tick();
    obus.p_valid = 1'b0;
    chk("ovf_next_sum", 32'(obus.sum), 1);
    obus.out_ready = 1'b1;
    tick();
    obus.out_ready = 1'b0;

    // asynchronous reset in the middle of a job
    bus.start = 1'b1; bus.len = 4'd3;
    tick();
    bus.start = 1'b0;
    bus.p_valid = 1'b1; bus.p_in = 10'd20;
    tick();
    bus.p_in = 10'd30;
    tick();
    bus.p_valid = 1'b0;
    chk("pre_rst_sum", 32'(bus.sum), 50);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sum", 32'(bus.sum), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_ovf", 32'(bus.ovf), 0);
    tick();
    rst_n = 1'b1;
    tick();
    rp = '0;
    rp[0] = 10'd3;
    run_job(0, rp, 0, 0, gs, go);
    chk("post_rst_sum", 32'(gs), 3);

    // random jobs against the arithmetic model
    for (int n = 0; n < 30; n++) begin
      l = $urandom_range(0, 15);
      tsum = 0;
      rp = '0;
      for (int j = 0; j <= l; j++) begin
        rp[j] = 10'($urandom_range(0, 961));
        tsum += int'(rp[j]);
      end
      exp_q.push_back(14'(tsum % 16384));
      exp_ovf_q.push_back(tsum >= 16384);
      run_job(l, rp, 2, $urandom_range(0, 3), gs, go);
      chk("rnd_sum", 32'(gs), 32'(exp_q.pop_front()));
      chk("rnd_ovf", 32'(go), 32'(exp_ovf_q.pop_front()));
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
